bp_me_mem_data_cmd_serializer: RTL

BP_ME_MEM_DATA_CMD_SERIALIZER -- requirements
Module: bp_me_mem_data_cmd_serializer

---
 rtl/bp_common_pkg.sv | 19 +
 rtl/bsg_counter_clear_up.sv | 30 +++
 rtl/bp_me_mem_data_cmd_serializer.sv | 106 ++++++++++
 3 files changed

// File: rtl/bp_common_pkg.sv
// Shared BlackParrot helpers: flit-count arithmetic and serializer FSM encoding.
package bp_common_pkg;

    // Number of link flits needed to carry a packet of the given width.
    function automatic int bp_ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // clog2 that never yields a zero-width vector, so a one-flit packet still gets a 1-bit index.
    function automatic int bp_safe_clog2(input int val);
        return (val <= 1) ? 1 : $clog2(val);
    endfunction

    typedef enum logic {
        e_ser_idle = 1'b0,
        e_ser_send = 1'b1
    } bp_ser_state_e;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up-counter with synchronous clear; clear wins over up and saturates at max_val_p.
module bsg_counter_clear_up
    import bp_common_pkg::*;
#(
    parameter int max_val_p = 3,
    parameter int width_p   = bp_safe_clog2(max_val_p + 1)
)
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] r_count;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= width_p'(up_i);
        end else if (up_i && (r_count != width_p'(max_val_p))) begin
            r_count <= r_count + width_p'(1);
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/bp_me_mem_data_cmd_serializer.sv
// Splits one CCE->memory data command packet into link flits, LSB flit first,
// with zero-bubble hand-off between consecutive packets.
module bp_me_mem_data_cmd_serializer
    import bp_common_pkg::*;
#(
    parameter int data_width_p = 600,
    parameter int flit_width_p = 64
)
(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [data_width_p-1:0] data_i,
    input  logic                    v_i,
    output logic                    yumi_o,
    output logic [flit_width_p-1:0] flit_o,
    output logic                    flit_v_o,
    output logic                    flit_last_o,
    input  logic                    flit_ready_i,
    output logic                    busy_o
);

    localparam int num_flits_lp    = bp_ceil_div(data_width_p, flit_width_p);
    localparam int idx_width_lp    = bp_safe_clog2(num_flits_lp);
    localparam int padded_width_lp = num_flits_lp * flit_width_p;

    bp_ser_state_e              r_state;
    bp_ser_state_e              w_state_next;
    logic [padded_width_lp-1:0] r_data;
    logic [padded_width_lp-1:0] w_padded;
    logic [idx_width_lp-1:0]    w_idx;
    logic                       w_handshake;
    logic                       w_last;
    logic                       w_load;
    logic                       w_up;
    logic                       w_yumi;
    int unsigned                w_base;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= e_ser_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            e_ser_idle: if (v_i) w_state_next = e_ser_send;
            e_ser_send: if (w_handshake && w_last && !v_i) w_state_next = e_ser_idle;
            default:    w_state_next = e_ser_idle;
        endcase
    end

    // A new packet is taken either from idle or on the final flit's handshake, never while in reset.
    always_comb begin
        w_yumi = 1'b0;
        w_up   = 1'b0;
        case (r_state)
            e_ser_idle: w_yumi = v_i;
            e_ser_send: begin
                w_yumi = w_handshake & w_last & v_i;
                w_up   = w_handshake & ~w_last;
            end
            default: w_yumi = 1'b0;
        endcase
        w_yumi = w_yumi & ~reset_i;
        w_load = w_yumi;
    end

    assign flit_v_o    = (r_state == e_ser_send);
    assign w_handshake = flit_v_o & flit_ready_i;
    assign w_last      = (r_state == e_ser_send) && (w_idx == idx_width_lp'(num_flits_lp - 1));
    assign flit_last_o = w_last;
    assign yumi_o      = w_yumi;
    assign busy_o      = (r_state == e_ser_send);

    always_comb begin
        w_padded                     = '0;
        w_padded[data_width_p-1:0]   = data_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_data <= '0;
        end else if (w_load) begin
            r_data <= w_padded;
        end
    end

    bsg_counter_clear_up #(
        .max_val_p (num_flits_lp - 1),
        .width_p   (idx_width_lp)
    ) u_flit_idx (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (w_load),
        .up_i    (w_up),
        .count_o (w_idx)
    );

    // Flits are picked from the held packet by index so the register never shifts.
    assign w_base = int'(w_idx) * flit_width_p;
    assign flit_o = r_data[w_base +: flit_width_p];

endmodule
